// File: rtl/sifive_reset_sequencer.sv
// rtl/sifive_reset_sequencer.sv - ordered reset release for up to 8 domains
// Waits for PLL lock, debounces it, then releases domains one at a time on ack.
module sifive_reset_sequencer #(
  parameter int DOMAINS     = 4,
  parameter int HOLD_BITS   = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               areset_n,
  input  logic               pll_locked,
  input  logic               sw_reset_req,
  input  logic [DOMAINS-1:0] domain_ack,
  output logic [DOMAINS-1:0] reset_out,
  output logic               ready,
  output logic               fault,
  output logic [3:0]         stage
);

  localparam int ACK_BITS = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int CW       = (HOLD_BITS > ACK_BITS) ? HOLD_BITS : ACK_BITS;
  localparam int IW       = (DOMAINS > 1) ? $clog2(DOMAINS) : 1;

  localparam logic [CW-1:0]      HOLD_LAST = CW'((64'd1 << HOLD_BITS) - 64'd1);
  localparam logic [CW-1:0]      ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0]      IDX_LAST  = IW'(DOMAINS - 1);
  localparam logic [DOMAINS-1:0] ALL_ONES  = '1;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    HOLD,
    RELEASE,
    WAIT_ACK,
    RUN,
    FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DOMAINS-1:0] reset_out_d;
  logic               ready_d, fault_d;
  logic [3:0]         stage_d;

  logic               lock_meta, lock_s;
  logic [DOMAINS-1:0] ack_meta, ack_s;

  logic [DOMAINS-1:0] idx_mask;
  logic               ack_hit;
  logic               abort;

  assign idx_mask = DOMAINS'(1) << idx_q;
  assign ack_hit  = |(ack_s & idx_mask);
  assign abort    = ~lock_s | sw_reset_req;

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      ack_meta  <= '0;
      ack_s     <= '0;
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      idx_q     <= '0;
      reset_out <= ALL_ONES;
      ready     <= 1'b0;
      fault     <= 1'b0;
      stage     <= 4'd0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
      ack_meta  <= domain_ack;
      ack_s     <= ack_meta;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      reset_out <= reset_out_d;
      ready     <= ready_d;
      fault     <= fault_d;
      stage     <= stage_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    reset_out_d = reset_out;
    ready_d     = ready;
    fault_d     = fault;
    stage_d     = stage;

    case (state_q)
      WAIT_LOCK: begin
        reset_out_d = ALL_ONES;
        ready_d     = 1'b0;
        stage_d     = 4'd0;
        if (lock_s) begin
          state_d = HOLD;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (!abort) begin
          reset_out_d = reset_out & ~idx_mask;
          stage_d     = 4'(idx_q) + 4'd1;
          cnt_d       = '0;
          state_d     = WAIT_ACK;
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      WAIT_ACK: begin
        if (abort) begin
          state_d = WAIT_LOCK;
        end else if (ack_hit) begin
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = RELEASE;
          end
        end else if (cnt_q == ACK_LAST) begin
          state_d     = FAULT;
          fault_d     = 1'b1;
          reset_out_d = ALL_ONES;
          ready_d     = 1'b0;
          stage_d     = 4'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (abort) state_d = WAIT_LOCK;
      end
      FAULT: begin
        // Only a software request leaves FAULT; lock loss is deliberately ignored.
        reset_out_d = ALL_ONES;
        fault_d     = 1'b1;
        ready_d     = 1'b0;
        stage_d     = 4'd0;
        if (sw_reset_req) begin
          fault_d = 1'b0;
          state_d = WAIT_LOCK;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Any abort forces every domain back into reset on the same edge.
    if (state_d == WAIT_LOCK && state_q != WAIT_LOCK && state_q != FAULT) begin
      reset_out_d = ALL_ONES;
      ready_d     = 1'b0;
      stage_d     = 4'd0;
      cnt_d       = '0;
    end
  end

endmodule

// File: tb/tb_sifive_reset_sequencer.sv
// tb/tb_sifive_reset_sequencer.sv - directed bench for sifive_reset_sequencer
// Table of per-step vectors for bring-up and software reset, plus corner sequences.
module tb_sifive_reset_sequencer;

  logic       clock = 1'b0;
  logic       areset_n;
  logic       pll_locked;
  logic       sw_reset_req;
  logic [2:0] domain_ack;
  logic [2:0] reset_out;
  logic       ready;
  logic       fault;
  logic [3:0] stage;

  int total = 0;
  int bad   = 0;

  sifive_reset_sequencer #(
    .DOMAINS    (3),
    .HOLD_BITS  (4),
    .ACK_TIMEOUT(8)
  ) dut (
    .clock       (clock),
    .areset_n    (areset_n),
    .pll_locked  (pll_locked),
    .sw_reset_req(sw_reset_req),
    .domain_ack  (domain_ack),
    .reset_out   (reset_out),
    .ready       (ready),
    .fault       (fault),
    .stage       (stage)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         n;
    logic       pll;
    logic       sw;
    logic [2:0] ack;
    logic [2:0] ro;
    logic       rdy;
    logic       flt;
    logic [3:0] stg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int n, input logic pll, input logic sw, input logic [2:0] ack,
                              input logic [2:0] ro, input logic rdy, input logic flt,
                              input logic [3:0] stg);
    vec_t v;
    v.n = n; v.pll = pll; v.sw = sw; v.ack = ack;
    v.ro = ro; v.rdy = rdy; v.flt = flt; v.stg = stg;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [2:0] ro, input logic rdy,
                           input logic flt, input logic [3:0] stg);
    check({name, ".reset_out"}, {5'd0, reset_out}, {5'd0, ro});
    check({name, ".ready"},     {7'd0, ready},     {7'd0, rdy});
    check({name, ".fault"},     {7'd0, fault},     {7'd0, flt});
    check({name, ".stage"},     {4'd0, stage},     {4'd0, stg});
  endtask

  // Each step advances one posedge and lands on the following negedge; sw is a one-edge pulse.
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      sw_reset_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    areset_n     = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    domain_ack   = 3'b000;
    cycles(2);
    areset_n     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    areset_n     = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    domain_ack   = 3'b000;
    @(negedge clock);
    @(negedge clock);
    check_out("reset_state", 3'b111, 1'b0, 1'b0, 4'd0);

    // Nominal bring-up from E0, then software reset in RUN and re-sequence.
    tbl.push_back(mk(19, 1, 0, 3'b000, 3'b111, 0, 0, 4'd0));
    tbl.push_back(mk( 1, 1, 0, 3'b000, 3'b110, 0, 0, 4'd1));
    tbl.push_back(mk( 3, 1, 0, 3'b001, 3'b110, 0, 0, 4'd1));
    tbl.push_back(mk( 1, 1, 0, 3'b001, 3'b100, 0, 0, 4'd2));
    tbl.push_back(mk( 3, 1, 0, 3'b011, 3'b100, 0, 0, 4'd2));
    tbl.push_back(mk( 1, 1, 0, 3'b011, 3'b000, 0, 0, 4'd3));
    tbl.push_back(mk( 2, 1, 0, 3'b111, 3'b000, 0, 0, 4'd3));
    tbl.push_back(mk( 1, 1, 0, 3'b111, 3'b000, 1, 0, 4'd3));
    tbl.push_back(mk( 5, 1, 0, 3'b111, 3'b000, 1, 0, 4'd3));
    tbl.push_back(mk( 1, 1, 1, 3'b000, 3'b111, 0, 0, 4'd0));
    tbl.push_back(mk(17, 1, 0, 3'b000, 3'b111, 0, 0, 4'd0));
    tbl.push_back(mk( 1, 1, 0, 3'b000, 3'b110, 0, 0, 4'd1));
    tbl.push_back(mk( 4, 1, 0, 3'b001, 3'b100, 0, 0, 4'd2));
    tbl.push_back(mk( 4, 1, 0, 3'b011, 3'b000, 0, 0, 4'd3));
    tbl.push_back(mk( 2, 1, 0, 3'b111, 3'b000, 0, 0, 4'd3));
    tbl.push_back(mk( 1, 1, 0, 3'b111, 3'b000, 1, 0, 4'd3));

    areset_n = 1'b1;
    foreach (tbl[k]) begin
      pll_locked   = tbl[k].pll;
      sw_reset_req = tbl[k].sw;
      domain_ack   = tbl[k].ack;
      cycles(tbl[k].n);
      check_out($sformatf("vec%0d", k), tbl[k].ro, tbl[k].rdy, tbl[k].flt, tbl[k].stg);
    end

    // Lock glitch at HOLD cnt=10: three low samples, then a fresh full hold.
    do_reset();
    pll_locked = 1'b1;
    cycles(13);
    pll_locked = 1'b0;
    cycles(3);
    pll_locked = 1'b1;
    cycles(4);
    check_out("glitch_no_release", 3'b111, 1'b0, 1'b0, 4'd0);
    cycles(15);
    check_out("glitch_rehold_end", 3'b111, 1'b0, 1'b0, 4'd0);
    cycles(1);
    check_out("glitch_release0", 3'b110, 1'b0, 1'b0, 4'd1);

    // Ack timeout on domain 1, lock loss ignored in FAULT, software reset recovers.
    do_reset();
    pll_locked = 1'b1;
    cycles(20);
    check_out("to_release0", 3'b110, 1'b0, 1'b0, 4'd1);
    domain_ack = 3'b001;
    cycles(11);
    check_out("to_before", 3'b100, 1'b0, 1'b0, 4'd2);
    cycles(1);
    check_out("to_fault", 3'b111, 1'b0, 1'b1, 4'd0);
    pll_locked = 1'b0;
    cycles(5);
    check_out("to_lockloss", 3'b111, 1'b0, 1'b1, 4'd0);
    pll_locked = 1'b1;
    domain_ack = 3'b000;
    cycles(3);
    sw_reset_req = 1'b1;
    cycles(1);
    check_out("to_sw_clear", 3'b111, 1'b0, 1'b0, 4'd0);
    cycles(17);
    check_out("to_rehold", 3'b111, 1'b0, 1'b0, 4'd0);
    cycles(1);
    check_out("to_rerelease", 3'b110, 1'b0, 1'b0, 4'd1);

    // ack_s[1] and sw_reset_req arrive together in WAIT_ACK idx=1: abort wins.
    do_reset();
    pll_locked = 1'b1;
    cycles(20);
    domain_ack = 3'b001;
    cycles(4);
    check_out("sim_idx1", 3'b100, 1'b0, 1'b0, 4'd2);
    domain_ack = 3'b011;
    cycles(2);
    sw_reset_req = 1'b1;
    cycles(1);
    check_out("sim_abort", 3'b111, 1'b0, 1'b0, 4'd0);
    domain_ack = 3'b000;
    cycles(2);
    check_out("sim_no_rel2", 3'b111, 1'b0, 1'b0, 4'd0);

    // Asynchronous reset between edges during WAIT_ACK.
    do_reset();
    pll_locked = 1'b1;
    cycles(20);
    domain_ack = 3'b001;
    cycles(5);
    check_out("ar_before", 3'b100, 1'b0, 1'b0, 4'd2);
    #2;
    areset_n = 1'b0;
    #1;
    check_out("ar_async", 3'b111, 1'b0, 1'b0, 4'd0);
    domain_ack = 3'b000;
    @(negedge clock);
    areset_n = 1'b1;
    cycles(19);
    check_out("ar_rehold", 3'b111, 1'b0, 1'b0, 4'd0);
    cycles(1);
    check_out("ar_release0", 3'b110, 1'b0, 1'b0, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
